// File: rtl/code_arb_pkg.sv
// Shared encodings and defaults for the colour-code detector arbiter.
package code_arb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT   = 3'd1;
  localparam logic [2:0] ST_SESSION = 3'd2;
  localparam logic [2:0] ST_UNLOCK  = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;
  localparam logic [2:0] ST_LOCKOUT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_GRANT   = ST_GRANT,
    S_SESSION = ST_SESSION,
    S_UNLOCK  = ST_UNLOCK,
    S_FAIL    = ST_FAIL,
    S_LOCKOUT = ST_LOCKOUT
  } state_t;

  // Bit positions inside a {Red,Green,Blue} keypad bus
  localparam int BTN_RED   = 2;
  localparam int BTN_GREEN = 1;
  localparam int BTN_BLUE  = 0;

  localparam int DEF_TIMEOUT_CYC = 1000;
  localparam int DEF_MAX_FAIL    = 3;
  localparam int DEF_LOCKOUT_CYC = 5000;
  localparam int DEF_UNLOCK_CYC  = 50;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/code_arb_timer.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module code_arb_timer #(
  parameter int W = 13
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/code_arbiter_ctrl.sv
// Session controller sharing one colour-code detector between two keypads.
// Optional lockout after repeated failures is built when CODE_LOCKOUT_EN is defined.
module code_arbiter_ctrl
  import code_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_FAIL    = DEF_MAX_FAIL,
  parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC,
  parameter int UNLOCK_CYC  = DEF_UNLOCK_CYC
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Req0,
  input  logic                          Req1,
  input  logic [2:0]                    Btn0,
  input  logic [2:0]                    Btn1,
  output logic                          Det_Rst,
  output logic                          Det_Start,
  output logic                          Det_Red,
  output logic                          Det_Green,
  output logic                          Det_Blue,
  input  logic                          Det_U,
  output logic [1:0]                    Grant,
  output logic                          Unlock0,
  output logic                          Unlock1,
  output logic                          Locked,
  output logic [$clog2(MAX_FAIL+1)-1:0] Fail_cnt
);

  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(max3(TIMEOUT_CYC, LOCKOUT_CYC, UNLOCK_CYC));
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] UN_LOAD  = TW'(UNLOCK_CYC - 1);
`ifdef CODE_LOCKOUT_EN
  localparam logic [TW-1:0] LO_LOAD  = TW'(LOCKOUT_CYC - 1);
`endif
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

  state_t          state, next_state;
  logic [1:0]      grant_q, grant_d;
  logic            rr_last_q, rr_last_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic [2:0]      own_btn;
  logic            own_req, own_any;

  assign own_btn = grant_q[1] ? Btn1 : (grant_q[0] ? Btn0 : 3'b000);
  assign own_req = (grant_q[1] & Req1) | (grant_q[0] & Req0);
  assign own_any = |own_btn;

  code_arb_timer #(.W(TW)) u_timer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // rr_last_q = 1 means keypad 1 was served last, so keypad 0 wins the first tie
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      grant_q   <= 2'b00;
      rr_last_q <= 1'b1;
      fail_q    <= '0;
    end else begin
      state     <= next_state;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    next_state = state;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    fail_d     = fail_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Req0 || Req1) begin
          next_state = S_GRANT;
          if (Req0 && Req1)
            grant_d = rr_last_q ? 2'b01 : 2'b10;
          else
            grant_d = Req0 ? 2'b01 : 2'b10;
        end
      end
      S_GRANT: begin
        next_state = S_SESSION;
        tmr_load   = 1'b1;
        tmr_val    = TO_LOAD;
      end
      // A detector hit outranks a simultaneous timeout or abort
      S_SESSION: begin
        if (Det_U) begin
          next_state = S_UNLOCK;
          fail_d     = '0;
          tmr_load   = 1'b1;
          tmr_val    = UN_LOAD;
        end else if ((tmr_zero && !own_any) || !own_req) begin
          next_state = S_FAIL;
          grant_d    = 2'b00;
          if (fail_q != FAIL_MAX)
            fail_d = fail_q + 1'b1;
        end else if (own_any) begin
          tmr_load = 1'b1;
          tmr_val  = TO_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_UNLOCK: begin
        if (tmr_zero) begin
          next_state = S_IDLE;
          rr_last_d  = grant_q[1];
          grant_d    = 2'b00;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_FAIL: begin
        next_state = S_IDLE;
`ifdef CODE_LOCKOUT_EN
        if (fail_q == FAIL_MAX) begin
          next_state = S_LOCKOUT;
          tmr_load   = 1'b1;
          tmr_val    = LO_LOAD;
        end
`endif
      end
      S_LOCKOUT: begin
`ifdef CODE_LOCKOUT_EN
        if (tmr_zero) begin
          next_state = S_IDLE;
          fail_d     = '0;
        end else begin
          tmr_dec = 1'b1;
        end
`else
        next_state = S_IDLE;
`endif
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign Det_Rst   = (state != S_GRANT) && (state != S_SESSION);
  assign Det_Start = (state == S_GRANT);
  assign Det_Red   = (state == S_SESSION) & own_btn[BTN_RED];
  assign Det_Green = (state == S_SESSION) & own_btn[BTN_GREEN];
  assign Det_Blue  = (state == S_SESSION) & own_btn[BTN_BLUE];
  assign Grant     = grant_q;
  assign Unlock0   = (state == S_UNLOCK) & grant_q[0];
  assign Unlock1   = (state == S_UNLOCK) & grant_q[1];
`ifdef CODE_LOCKOUT_EN
  assign Locked    = (state == S_LOCKOUT);
`else
  assign Locked    = 1'b0;
`endif
  assign Fail_cnt  = fail_q;

endmodule
